// File: rtl/vga_sync_porch_if.sv
// Pixel-side bundle for vga_sync_porch: generator-style visible-area syncs and RGB in,
// porched active-low VGA syncs, delayed RGB and lock status out.
interface vga_sync_porch_if #(
  parameter int VIDEO_WIDTH = 4
);
  logic                   i_HSync;
  logic                   i_VSync;
  logic [VIDEO_WIDTH-1:0] i_Red;
  logic [VIDEO_WIDTH-1:0] i_Grn;
  logic [VIDEO_WIDTH-1:0] i_Blu;
  logic                   o_HSync;
  logic                   o_VSync;
  logic [VIDEO_WIDTH-1:0] o_Red;
  logic [VIDEO_WIDTH-1:0] o_Grn;
  logic [VIDEO_WIDTH-1:0] o_Blu;
  logic                   o_Locked;

  modport master (
    output i_HSync, i_VSync, i_Red, i_Grn, i_Blu,
    input  o_HSync, o_VSync, o_Red, o_Grn, o_Blu, o_Locked
  );

  modport slave (
    input  i_HSync, i_VSync, i_Red, i_Grn, i_Blu,
    output o_HSync, o_VSync, o_Red, o_Grn, o_Blu, o_Locked
  );
endinterface

// File: rtl/vga_sync_porch.sv
// Regenerates col/row from upstream visible-area syncs and drives porched active-low VGA syncs,
// keeping RGB 2 cycles behind its input. Define SYNC_PORCH_BLANK_EN to force RGB to 0 outside the visible area.
module vga_sync_porch #(
  parameter int TOTAL_COLS    = 800,
  parameter int TOTAL_ROWS    = 525,
  parameter int ACTIVE_COLS   = 640,
  parameter int ACTIVE_ROWS   = 480,
  parameter int FRONT_PORCH_H = 16,
  parameter int BACK_PORCH_H  = 48,
  parameter int FRONT_PORCH_V = 10,
  parameter int BACK_PORCH_V  = 33,
  parameter int VIDEO_WIDTH   = 4
) (
  input logic              i_Clk,
  input logic              i_Reset,
  vga_sync_porch_if.slave  vga
);

  localparam logic [9:0] COL_LAST  = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] ROW_LAST  = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] COL_VIS   = 10'(ACTIVE_COLS);
  localparam logic [9:0] ROW_VIS   = 10'(ACTIVE_ROWS);
  localparam logic [9:0] HS_FIRST  = 10'(ACTIVE_COLS + FRONT_PORCH_H);
  localparam logic [9:0] HS_LAST   = 10'(TOTAL_COLS - BACK_PORCH_H - 1);
  localparam logic [9:0] VS_FIRST  = 10'(ACTIVE_ROWS + FRONT_PORCH_V);
  localparam logic [9:0] VS_LAST   = 10'(TOTAL_ROWS - BACK_PORCH_V - 1);

  logic                   vSync1_q;
  logic                   vSync2_q;
  logic [VIDEO_WIDTH-1:0] red1_q, grn1_q, blu1_q;

  logic [9:0]             col_q, col_d;
  logic [9:0]             row_q, row_d;
  logic                   frameStart;
  logic                   blank;

  logic                   hSync_q, hSync_d;
  logic                   vSync_q, vSync_d;
  logic                   locked_q, locked_d;
  logic [VIDEO_WIDTH-1:0] red_q, red_d;
  logic [VIDEO_WIDTH-1:0] grn_q, grn_d;
  logic [VIDEO_WIDTH-1:0] blu_q, blu_d;

  // Line phase is taken from the VSync rising edge alone, so i_HSync is not needed here.
  // Sync stage resets high so an already-high i_VSync cannot fake a frame start.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      vSync1_q <= 1'b1;
      vSync2_q <= 1'b1;
      red1_q   <= '0;
      grn1_q   <= '0;
      blu1_q   <= '0;
    end else begin
      vSync1_q <= vga.i_VSync;
      vSync2_q <= vSync1_q;
      red1_q   <= vga.i_Red;
      grn1_q   <= vga.i_Grn;
      blu1_q   <= vga.i_Blu;
    end
  end

  // col_d/row_d is the position of the pixel currently in stage 1; col_q/row_q hold the previous one.
  always_comb begin
    frameStart = vSync1_q & ~vSync2_q;
    col_d      = col_q + 10'd1;
    row_d      = row_q;
    if (col_q >= COL_LAST) begin
      col_d = '0;
      row_d = (row_q >= ROW_LAST) ? 10'd0 : row_q + 10'd1;
    end
    if (frameStart) begin
      col_d = '0;
      row_d = '0;
    end

    hSync_d  = ~((col_d >= HS_FIRST) && (col_d <= HS_LAST));
    vSync_d  = ~((row_d >= VS_FIRST) && (row_d <= VS_LAST));
    locked_d = locked_q | frameStart;

    blank = 1'b0;
`ifdef SYNC_PORCH_BLANK_EN
    blank = (col_d >= COL_VIS) || (row_d >= ROW_VIS);
`endif
    red_d = blank ? '0 : red1_q;
    grn_d = blank ? '0 : grn1_q;
    blu_d = blank ? '0 : blu1_q;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      col_q    <= '0;
      row_q    <= '0;
      hSync_q  <= 1'b1;
      vSync_q  <= 1'b1;
      locked_q <= 1'b0;
      red_q    <= '0;
      grn_q    <= '0;
      blu_q    <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      hSync_q  <= hSync_d;
      vSync_q  <= vSync_d;
      locked_q <= locked_d;
      red_q    <= red_d;
      grn_q    <= grn_d;
      blu_q    <= blu_d;
    end
  end

  assign vga.o_HSync  = hSync_q;
  assign vga.o_VSync  = vSync_q;
  assign vga.o_Locked = locked_q;
  assign vga.o_Red    = red_q;
  assign vga.o_Grn    = grn_q;
  assign vga.o_Blu    = blu_q;

endmodule
